// File: rtl/core_bus_arbiter_if.sv
// Bus bundle for core_bus_arbiter: ibus/dbus master ports on the core side, single memory port on the far side.
// The slave modport is the arbiter's view; the master modport is the view of whatever drives it (core + memory).
interface core_bus_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8
);
    logic              i_valid;
    logic [ADDR_W-1:0] i_addr;
    logic              i_addr_ok;
    logic              i_data_ok;
    logic [DATA_W-1:0] i_rdata;

    logic              d_valid;
    logic [ADDR_W-1:0] d_addr;
    logic [2:0]        d_size;
    logic [STRB_W-1:0] d_strobe;
    logic [DATA_W-1:0] d_wdata;
    logic              d_addr_ok;
    logic              d_data_ok;
    logic [DATA_W-1:0] d_rdata;

    logic              m_valid;
    logic              m_write;
    logic [ADDR_W-1:0] m_addr;
    logic [2:0]        m_size;
    logic [STRB_W-1:0] m_strobe;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ready;
    logic              m_rvalid;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  i_valid, i_addr, d_valid, d_addr, d_size, d_strobe, d_wdata,
               m_ready, m_rvalid, m_rdata,
        output i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
               m_valid, m_write, m_addr, m_size, m_strobe, m_wdata
    );

    modport master (
        output i_valid, i_addr, d_valid, d_addr, d_size, d_strobe, d_wdata,
               m_ready, m_rvalid, m_rdata,
        input  i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
               m_valid, m_write, m_addr, m_size, m_strobe, m_wdata
    );
endinterface

// File: rtl/core_bus_arbiter.sv
// One-at-a-time arbiter of ibus/dbus onto the memory port. Define ARB_ROUND_ROBIN_EN for
// round-robin tie breaking; otherwise dbus has fixed priority.
// Handshake: a master holds valid until its data_ok; memory takes m_valid when m_ready is high
// and answers with a single m_rvalid pulse; addr_ok/data_ok are one-cycle pulses to the owner only.
module core_bus_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic               clk,
    input  logic               reset,
    core_bus_arbiter_if.slave  bus,
    output logic [1:0]         dbg_state_o
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    state_t            state_q;
    logic              owner_q;
    logic              m_valid_q;
    logic              m_write_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [2:0]        m_size_q;
    logic [STRB_W-1:0] m_strobe_q;
    logic [DATA_W-1:0] m_wdata_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              i_data_ok_q;
    logic              d_data_ok_q;
    logic              grant_dbus;
    logic              rsp_take;

`ifdef ARB_ROUND_ROBIN_EN
    logic              last_q;

    always_comb begin
        grant_dbus = bus.d_valid && (!bus.i_valid || (last_q == OWNER_I));
    end
`else
    always_comb begin
        grant_dbus = bus.d_valid;
    end
`endif

    // A response counts only while a request is outstanding, including the accept cycle itself.
    assign rsp_take = bus.m_rvalid &&
                      (((state_q == S_REQ) && bus.m_ready) || (state_q == S_WAIT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            owner_q     <= OWNER_D;
            m_valid_q   <= 1'b0;
            m_write_q   <= 1'b0;
            m_addr_q    <= '0;
            m_size_q    <= '0;
            m_strobe_q  <= '0;
            m_wdata_q   <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_data_ok_q <= 1'b0;
            d_data_ok_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q      <= OWNER_I;
`endif
        end else begin
            i_data_ok_q <= 1'b0;
            d_data_ok_q <= 1'b0;
            if (rsp_take) begin
                if (owner_q == OWNER_D) begin
                    d_rdata_q   <= bus.m_rdata;
                    d_data_ok_q <= 1'b1;
                end else begin
                    i_rdata_q   <= bus.m_rdata;
                    i_data_ok_q <= 1'b1;
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (bus.i_valid || bus.d_valid) begin
                        m_valid_q <= 1'b1;
                        state_q   <= S_REQ;
`ifdef ARB_ROUND_ROBIN_EN
                        last_q    <= grant_dbus;
`endif
                        if (grant_dbus) begin
                            owner_q    <= OWNER_D;
                            m_write_q  <= |bus.d_strobe;
                            m_addr_q   <= bus.d_addr;
                            m_size_q   <= bus.d_size;
                            m_strobe_q <= bus.d_strobe;
                            m_wdata_q  <= bus.d_wdata;
                        end else begin
                            owner_q    <= OWNER_I;
                            m_write_q  <= 1'b0;
                            m_addr_q   <= bus.i_addr;
                            m_size_q   <= 3'b010;
                            m_strobe_q <= '0;
                            m_wdata_q  <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= bus.m_rvalid ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.m_rvalid) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // addr_ok is the accept cycle itself, so it follows m_ready combinationally.
    assign bus.i_addr_ok = (state_q == S_REQ) && bus.m_ready && (owner_q == OWNER_I);
    assign bus.d_addr_ok = (state_q == S_REQ) && bus.m_ready && (owner_q == OWNER_D);
    assign bus.i_data_ok = i_data_ok_q;
    assign bus.d_data_ok = d_data_ok_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_write   = m_write_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_size    = m_size_q;
    assign bus.m_strobe  = m_strobe_q;
    assign bus.m_wdata   = m_wdata_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_core_bus_arbiter.sv
// Bench for core_bus_arbiter: memory responder, request/response scoreboards and directed + random scenarios.
module tb_core_bus_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SW = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  core_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) bus ();

  core_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic          owner;
    logic          write;
    logic [AW-1:0] addr;
    logic [2:0]    size;
    logic [SW-1:0] strobe;
    logic [DW-1:0] wdata;
  } req_t;

  req_t          req_q[$];
  logic [DW-1:0] i_exp_q[$];
  logic [DW-1:0] d_exp_q[$];

  int rdy_dly = 0, rv_dly = 0;
  bit stray = 0;
  int i_rem = 0, d_rem = 0;
  int i_aok_cnt = 0, d_aok_cnt = 0, i_dok_cnt = 0, d_dok_cnt = 0, mval_cnt = 0;

  function automatic logic [DW-1:0] resp_of(input logic [AW-1:0] a);
    if (a == 64'h8000_0000) return 64'h13;
    return {a[31:0] ^ 32'h5A5A_0F0F, ~a[31:0]};
  endfunction

  task automatic push_i(input logic [AW-1:0] a);
    req_t e;
    e = '{owner: 1'b0, write: 1'b0, addr: a, size: 3'b010, strobe: '0, wdata: '0};
    req_q.push_back(e);
    i_exp_q.push_back(resp_of(a));
  endtask

  task automatic push_d(input logic [AW-1:0] a, input logic [2:0] sz,
                        input logic [SW-1:0] st, input logic [DW-1:0] wd);
    req_t e;
    e = '{owner: 1'b1, write: |st, addr: a, size: sz, strobe: st, wdata: wd};
    req_q.push_back(e);
    d_exp_q.push_back(resp_of(a));
  endtask

  // memory responder: checks request fields every m_valid cycle and the owner at accept
  initial begin : mem_model
    bit            pend = 0;
    int            rv_cnt = 0;
    int            wait_cnt = 0;
    logic [DW-1:0] pend_data = '0;
    req_t          e;
    bus.m_ready = 1'b0;
    bus.m_rvalid = 1'b0;
    bus.m_rdata = '0;
    forever begin
      @(negedge clk);
      bus.m_ready = 1'b0;
      bus.m_rvalid = 1'b0;
      if (!reset) begin
        pend = 0;
        wait_cnt = 0;
      end else if (stray) begin
        bus.m_rvalid = 1'b1;
        bus.m_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        stray = 0;
      end else if (pend) begin
        if (rv_cnt == 0) begin
          bus.m_rvalid = 1'b1;
          bus.m_rdata = pend_data;
          pend = 0;
        end else begin
          rv_cnt--;
        end
      end else if (bus.m_valid) begin
        mval_cnt++;
        if (req_q.size() == 0) begin
          check("req_unexpected", 64'd1, 64'd0);
        end else begin
          e = req_q[0];
          check("req_write", {63'd0, bus.m_write}, {63'd0, e.write});
          check("req_addr", bus.m_addr, e.addr);
          check("req_size", {61'd0, bus.m_size}, {61'd0, e.size});
          check("req_strobe", {56'd0, bus.m_strobe}, {56'd0, e.strobe});
          check("req_wdata", bus.m_wdata, e.wdata);
          if (wait_cnt >= rdy_dly) begin
            void'(req_q.pop_front());
            wait_cnt = 0;
            bus.m_ready = 1'b1;
            pend_data = resp_of(bus.m_addr);
            if (rv_dly == 0) begin
              bus.m_rvalid = 1'b1;
              bus.m_rdata = pend_data;
            end else begin
              pend = 1;
              rv_cnt = rv_dly - 1;
            end
            #1;
            check("aok_owner", {62'd0, bus.d_addr_ok, bus.i_addr_ok},
                  e.owner ? 64'd2 : 64'd1);
            i_aok_cnt += int'(bus.i_addr_ok);
            d_aok_cnt += int'(bus.d_addr_ok);
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  // response scoreboard; also releases a master's valid once its last response arrives
  initial begin : rsp_monitor
    forever begin
      @(negedge clk);
      if (bus.i_data_ok || bus.d_data_ok)
        check("dok_exclusive", {63'd0, bus.i_data_ok & bus.d_data_ok}, 64'd0);
      if (bus.i_data_ok) begin
        i_dok_cnt++;
        if (i_exp_q.size() == 0) check("i_dok_unexpected", 64'd1, 64'd0);
        else check("i_rdata", bus.i_rdata, i_exp_q.pop_front());
        if (i_rem > 0) i_rem--;
        if (i_rem == 0) bus.i_valid = 1'b0;
      end
      if (bus.d_data_ok) begin
        d_dok_cnt++;
        if (d_exp_q.size() == 0) check("d_dok_unexpected", 64'd1, 64'd0);
        else check("d_rdata", bus.d_rdata, d_exp_q.pop_front());
        if (d_rem > 0) d_rem--;
        if (d_rem == 0) bus.d_valid = 1'b0;
      end
    end
  end

  task automatic wait_done(input string tag, input int max_cyc);
    bit ok = 0;
    for (int n = 0; n < max_cyc; n++) begin
      @(negedge clk);
      #3;
      if (i_rem == 0 && d_rem == 0 && req_q.size() == 0 && i_exp_q.size() == 0 &&
          d_exp_q.size() == 0 && dbg_state == 2'd0) begin
        ok = 1;
        break;
      end
    end
    check(tag, {63'd0, ok}, 64'd1);
  endtask

  task automatic drive_i(input logic [AW-1:0] a);
    bus.i_addr = a;
    bus.i_valid = 1'b1;
  endtask

  task automatic drive_d(input logic [AW-1:0] a, input logic [2:0] sz,
                         input logic [SW-1:0] st, input logic [DW-1:0] wd);
    bus.d_addr = a;
    bus.d_size = sz;
    bus.d_strobe = st;
    bus.d_wdata = wd;
    bus.d_valid = 1'b1;
  endtask

  initial begin : main
    int            base_a, base_d, base_m;
    bit            seen;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [SW-1:0] st;
    logic [2:0]    sz;

    reset = 1'b0;
    bus.i_valid = 1'b0; bus.i_addr = '0;
    bus.d_valid = 1'b0; bus.d_addr = '0; bus.d_size = '0; bus.d_strobe = '0; bus.d_wdata = '0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    check("rst_m_valid", {63'd0, bus.m_valid}, 64'd0);
    check("rst_m_addr", bus.m_addr, 64'd0);
    check("rst_rdata", bus.i_rdata | bus.d_rdata, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // fetch, zero-wait memory: exact cycle timing
    push_i(64'h8000_0000);
    i_rem = 1;
    drive_i(64'h8000_0000);
    @(posedge clk);
    @(negedge clk);
    #2;
    check("fetch_m_valid_c1", {63'd0, bus.m_valid}, 64'd1);
    check("fetch_i_addr_ok_c1", {62'd0, bus.d_addr_ok, bus.i_addr_ok}, 64'd1);
    @(negedge clk);
    #2;
    check("fetch_i_data_ok_c2", {63'd0, bus.i_data_ok}, 64'd1);
    check("fetch_i_rdata_c2", bus.i_rdata, 64'h13);
    wait_done("fetch_done", 20);

    // tie: dbus first; then exactly one IDLE cycle before ibus goes out
`ifdef ARB_ROUND_ROBIN_EN
    push_d(64'h8000_2000, 3'b011, 8'h00, 64'd0);
    push_i(64'h8000_0100);
    push_d(64'h8000_2000, 3'b011, 8'h00, 64'd0);
    push_i(64'h8000_0100);
    d_rem = 2;
    i_rem = 2;
`else
    push_d(64'h8000_2000, 3'b011, 8'h00, 64'd0);
    push_i(64'h8000_0100);
    d_rem = 1;
    i_rem = 1;
`endif
    drive_d(64'h8000_2000, 3'b011, 8'h00, 64'd0);
    drive_i(64'h8000_0100);
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      #2;
      if (bus.d_data_ok) begin
        seen = 1;
        break;
      end
    end
    check("tie_first_d_dok", {63'd0, seen}, 64'd1);
    @(negedge clk);
    #2;
    check("tie_gap_idle", {62'd0, dbg_state}, 64'd0);
    @(negedge clk);
    #2;
    check("tie_second_req", {63'd0, bus.m_valid}, 64'd1);
    check("tie_second_addr", bus.m_addr, 64'h8000_0100);
    wait_done("tie_done", 60);

    // store with memory wait states
    rdy_dly = 3;
    rv_dly = 2;
    base_a = d_aok_cnt; base_d = d_dok_cnt; base_m = mval_cnt;
    push_d(64'h8000_1000, 3'b011, 8'hFF, 64'hDEAD);
    d_rem = 1;
    drive_d(64'h8000_1000, 3'b011, 8'hFF, 64'hDEAD);
    wait_done("store_done", 30);
    check("store_mvalid_cycles", 64'(mval_cnt - base_m), 64'd4);
    check("store_addr_ok_pulses", 64'(d_aok_cnt - base_a), 64'd1);
    check("store_data_ok_pulses", 64'(d_dok_cnt - base_d), 64'd1);

    // stray m_rvalid while idle must be ignored
    base_d = d_dok_cnt;
    stray = 1;
    repeat (4) @(negedge clk);
    #2;
    check("stray_d_rdata", bus.d_rdata, resp_of(64'h8000_1000));
    check("stray_no_dok", 64'(d_dok_cnt - base_d), 64'd0);

    // random single-requester traffic
    for (int k = 0; k < 24; k++) begin
      rdy_dly = $urandom_range(0, 3);
      rv_dly = $urandom_range(0, 3);
      a = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
        push_i(a);
        i_rem = 1;
        @(negedge clk);
        drive_i(a);
      end else begin
        wd = {$urandom, $urandom};
        sz = 3'($urandom_range(0, 7));
        st = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
        push_d(a, sz, st, wd);
        d_rem = 1;
        @(negedge clk);
        drive_d(a, sz, st, wd);
      end
      wait_done("rand_done", 30);
    end

    // reset while m_valid is up in REQ
    rdy_dly = 100;
    rv_dly = 0;
    push_i(64'h8000_0400);
    i_rem = 1;
    @(negedge clk);
    drive_i(64'h8000_0400);
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      #2;
      if (bus.m_valid) begin
        seen = 1;
        break;
      end
    end
    check("rstmid_in_req", {63'd0, seen}, 64'd1);
    reset = 1'b0;
    #1;
    check("rstmid_state", {62'd0, dbg_state}, 64'd0);
    check("rstmid_m_valid", {63'd0, bus.m_valid}, 64'd0);
    check("rstmid_addr_ok", {62'd0, bus.i_addr_ok, bus.d_addr_ok}, 64'd0);
    check("rstmid_data_ok", {62'd0, bus.i_data_ok, bus.d_data_ok}, 64'd0);
    check("rstmid_m_fields", bus.m_addr | bus.m_wdata |
          {53'd0, bus.m_write, bus.m_size, bus.m_strobe}, 64'd0);
    check("rstmid_rdata", bus.i_rdata | bus.d_rdata, 64'd0);
    req_q.delete();
    i_exp_q.delete();
    i_rem = 0;
    bus.i_valid = 1'b0;
    rdy_dly = 0;
    base_a = i_dok_cnt;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("rstmid_no_dok", 64'(i_dok_cnt - base_a), 64'd0);

    // dbus drops valid while waiting for its response; ibus follows
    rv_dly = 3;
    base_d = d_dok_cnt;
    push_d(64'h8000_3000, 3'b010, 8'h00, 64'd0);
    push_i(64'h8000_0800);
    d_rem = 1;
    i_rem = 1;
    drive_d(64'h8000_3000, 3'b010, 8'h00, 64'd0);
    drive_i(64'h8000_0800);
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      #2;
      if (dbg_state == 2'd2) begin
        seen = 1;
        break;
      end
    end
    check("drop_reached_wait", {63'd0, seen}, 64'd1);
    bus.d_valid = 1'b0;
    d_rem = 0;
    wait_done("drop_done", 40);
    check("drop_d_dok_once", 64'(d_dok_cnt - base_d), 64'd1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
